// File: rtl/sw_pkg.sv
// Shared state encoding and default timing constants for the stop-watch
// control front end.
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  // 50 MHz system clock: 100 Hz count enable, 20 ms debounce window.
  localparam int SW_DIV_DEF       = 500000;
  localparam int SW_DB_CYCLES_DEF = 1000000;

endpackage

// File: rtl/sw_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, and a
// one-cycle press pulse on each accepted rising level.
module sw_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_p0  <= raw;
      sync_p1  <= sync_p0;
      stable_d <= stable;
      // A new level is accepted only after DB_CYCLES disagreeing samples in a row.
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = stable & ~stable_d;

endmodule

// File: rtl/sw_ctrl.sv
// Stop-watch control front end: debounced buttons, run/pause/lap FSM,
// tick prescaler and chain clear. Lap view is built in when SW_LAP_EN is defined.
module sw_ctrl
  import sw_pkg::*;
#(
  parameter int DIV       = SW_DIV_DEF,
  parameter int DB_CYCLES = SW_DB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_cl,
  output logic       tick,
  output logic       clr,
  output logic       hold,
  output logic [1:0] state
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  sw_state_t     state_q;
  sw_state_t     state_nxt;
  logic          clr_q;
  logic          clr_nxt;
  logic [PW-1:0] pre;
  logic          ev_ss;
  logic          ev_cl;
  logic          counting;

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_ss),
    .press (ev_ss)
  );

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_cl (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_cl),
    .press (ev_cl)
  );

  // Start/stop takes priority; a clear/lap press in the same cycle is dropped.
  always_comb begin
    state_nxt = state_q;
    clr_nxt   = 1'b0;
    if (ev_ss) begin
      case (state_q)
        IDLE, PAUSE: state_nxt = RUN;
        default:     state_nxt = PAUSE;
      endcase
    end else if (ev_cl) begin
      case (state_q)
        IDLE: clr_nxt = 1'b1;
        PAUSE: begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
        end
`ifdef SW_LAP_EN
        RUN: state_nxt = LAP;
        LAP: state_nxt = RUN;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      clr_q   <= clr_nxt;
    end
  end

  assign counting = (state_q == RUN) || (state_q == LAP);

  // PAUSE keeps the fractional phase so resuming does not lose sub-tick time.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (counting) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
    end else if (state_q == IDLE) begin
      pre <= '0;
    end
  end

`ifdef SW_LAP_EN
  logic hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= (state_nxt == LAP);
    end
  end

  assign hold = hold_q;
`else
  assign hold = 1'b0;
`endif

  assign tick  = counting & (pre == PRE_LAST);
  assign clr   = clr_q;
  assign state = state_q;

endmodule

// File: tb/tb_sw_ctrl.sv
// Self-checking bench for sw_ctrl (DIV=5, DB_CYCLES=4): directed table,
// hand-written timing sequences and randomized buttons against a reference model.
module tb_sw_ctrl;

  localparam int DIV  = 5;
  localparam int DBC  = 4;
  localparam int LOGN = 1024;
`ifdef SW_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_cl = 1'b0;
  logic       tick;
  logic       clr;
  logic       hold;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  sw_ctrl #(.DIV(DIV), .DB_CYCLES(DBC)) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_ss (btn_ss),
    .btn_cl (btn_cl),
    .tick   (tick),
    .clr    (clr),
    .hold   (hold),
    .state  (state)
  );

  always #5 clk = ~clk;

  // Reference model: state numbers 0..3, raw sample log per button.
  int m_state;
  int m_pre;
  bit m_clr;
  int k_edge;
  bit rawlog [2][LOGN];
  int last_flip [2];
  bit m_stable [2];
  bit m_press [2];

  int tick_cnt;
  int clr_cnt;

  function automatic bit s_at(int b, int k);
    if (k < 2) return 1'b0;
    return rawlog[b][k-2];
  endfunction

  // Stable level flips once the synchronised input has disagreed with it on
  // each of the last DBC edges since its previous flip.
  function automatic void db_step(int b, bit r);
    bit ok;
    rawlog[b][k_edge] = r;
    m_press[b] = 1'b0;
    ok = (k_edge - last_flip[b]) >= DBC;
    for (int j = k_edge - DBC + 1; j <= k_edge; j++)
      if (ok && s_at(b, j) == m_stable[b]) ok = 1'b0;
    if (ok) begin
      m_stable[b]  = ~m_stable[b];
      last_flip[b] = k_edge;
      m_press[b]   = m_stable[b];
    end
  endfunction

  function automatic void model_step(bit r, bit s, bit c);
    int  ns;
    bit  nclr;
    if (r) begin
      m_state = 0;
      m_pre   = 0;
      m_clr   = 1'b0;
      k_edge  = 0;
      for (int b = 0; b < 2; b++) begin
        m_stable[b]  = 1'b0;
        m_press[b]   = 1'b0;
        last_flip[b] = -1;
      end
    end else begin
      if (k_edge >= LOGN) begin
        $display("FAIL model_log: edge %0d exceeds log size %0d", k_edge, LOGN);
        $fatal(1, "model log overflow");
      end
      ns   = m_state;
      nclr = 1'b0;
      if (m_press[0]) begin
        ns = (m_state == 1 || m_state == 3) ? 2 : 1;
      end else if (m_press[1]) begin
        case (m_state)
          0: nclr = 1'b1;
          1: ns = LAP_ON ? 3 : 1;
          2: begin ns = 0; nclr = 1'b1; end
          default: ns = 1;
        endcase
      end
      if (m_state == 1 || m_state == 3) m_pre = (m_pre + 1) % DIV;
      else if (m_state == 0)            m_pre = 0;
      m_state = ns;
      m_clr   = nclr;
      db_step(0, s);
      db_step(1, c);
      k_edge++;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit c);
    int exp_tick;
    rst    = r;
    btn_ss = s;
    btn_cl = c;
    @(posedge clk);
    model_step(r, s, c);
    @(negedge clk);
    exp_tick = ((m_state == 1 || m_state == 3) && m_pre == DIV - 1) ? 1 : 0;
    check("m_state", state, m_state);
    check("m_tick", tick, exp_tick);
    check("m_clr", clr, m_clr);
    check("m_hold", hold, (m_state == 3) ? 1 : 0);
    check("tick_clr_excl", tick & clr, 0);
    if (tick) tick_cnt++;
    if (clr)  clr_cnt++;
  endtask

  task automatic run(input bit s, input bit c, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, s, c);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    tick_cnt = 0;
    clr_cnt  = 0;
  endtask

  typedef struct {
    bit ss;
    bit cl;
    int exp_state;
    int exp_hold;
    int exp_clr;
  } vec_t;

  vec_t tbl [14];

  int  rise;
  int  first_tick;
  int  len_ss;
  int  len_cl;
  bit  lvl_ss;
  bit  lvl_cl;
  bit  rr;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lapst;
    lapst = LAP_ON ? 3 : 1;
    tbl[0]  = '{1'b1, 1'b0, 1,     0,      0};
    tbl[1]  = '{1'b0, 1'b1, lapst, LAP_ON, 0};
    tbl[2]  = '{1'b0, 1'b1, 1,     0,      0};
    tbl[3]  = '{1'b1, 1'b0, 2,     0,      0};
    tbl[4]  = '{1'b1, 1'b0, 1,     0,      0};
    tbl[5]  = '{1'b1, 1'b0, 2,     0,      0};
    tbl[6]  = '{1'b0, 1'b1, 0,     0,      1};
    tbl[7]  = '{1'b0, 1'b1, 0,     0,      1};
    tbl[8]  = '{1'b1, 1'b1, 1,     0,      0};
    tbl[9]  = '{1'b1, 1'b1, 2,     0,      0};
    tbl[10] = '{1'b1, 1'b0, 1,     0,      0};
    tbl[11] = '{1'b0, 1'b1, lapst, LAP_ON, 0};
    tbl[12] = '{1'b1, 1'b0, 2,     0,      0};
    tbl[13] = '{1'b0, 1'b1, 0,     0,      1};

    // Reset values
    do_reset();
    check("rst_state", state, 0);
    check("rst_tick", tick, 0);
    check("rst_clr", clr, 0);
    check("rst_hold", hold, 0);

    // Start latency and tick period
    rise = -1;
    first_tick = -1;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, i < 10, 1'b0);
      if (rise < 0 && state == 2'd1) rise = i;
      if (first_tick < 0 && tick) first_tick = i;
    end
    check("t1_run_edge", rise, 6);
    check("t1_first_tick", first_tick, 10);
    check("t1_ticks", tick_cnt, 2);

    // Glitch one cycle shorter than the window is rejected
    do_reset();
    run(1'b1, 1'b0, 3);
    run(1'b0, 1'b0, 10);
    check("t2_glitch_state", state, 0);
    check("t2_glitch_ticks", tick_cnt, 0);
    check("t2_glitch_clrs", clr_cnt, 0);
    // Exactly the window length is accepted
    run(1'b1, 1'b0, 4);
    run(1'b0, 1'b0, 3);
    check("t2_min_press", state, 1);

    // Pause keeps the prescaler phase
    do_reset();
    run(1'b1, 1'b0, 4);
    run(1'b0, 1'b0, 8);
    check("t3_running", state, 1);
    run(1'b1, 1'b0, 4);
    run(1'b0, 1'b0, 3);
    check("t3_paused", state, 2);
    check("t3_run_ticks", tick_cnt, 2);
    tick_cnt = 0;
    run(1'b0, 1'b0, 10);
    run(1'b1, 1'b0, 4);
    run(1'b0, 1'b0, 2);
    check("t3_pause_no_tick", tick_cnt, 0);
    check("t3_still_paused", state, 2);
    cyc(1'b0, 1'b0, 1'b0);
    check("t3_resumed", state, 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("t3_no_tick_yet", tick, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("t3_tick_phase", tick, 1);

    // Button held through reset gives exactly one press
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    run(1'b1, 1'b0, 6);
    check("held_rst_wait", state, 0);
    cyc(1'b0, 1'b1, 1'b0);
    check("held_rst_press", state, 1);
    run(1'b1, 1'b0, 20);
    check("held_no_repeat", state, 1);

    // Reset asserted mid-run
    cyc(1'b1, 1'b0, 1'b0);
    check("midrst_state", state, 0);
    check("midrst_tick", tick, 0);
    check("midrst_clr", clr, 0);
    check("midrst_hold", hold, 0);

    // FSM walk: each row presses for 6 cycles then releases for 6
    do_reset();
    for (int i = 0; i < 14; i++) begin
      clr_cnt = 0;
      run(tbl[i].ss, tbl[i].cl, 6);
      run(1'b0, 1'b0, 6);
      check($sformatf("row%0d_state", i), state, tbl[i].exp_state);
      check($sformatf("row%0d_hold", i), hold, tbl[i].exp_hold);
      check($sformatf("row%0d_clr", i), clr_cnt, tbl[i].exp_clr);
    end

    // Randomized button activity against the model
    for (int blk = 0; blk < 6; blk++) begin
      lvl_ss = 1'($urandom_range(0, 1));
      lvl_cl = 1'($urandom_range(0, 1));
      cyc(1'b1, lvl_ss, lvl_cl);
      len_ss = 0;
      len_cl = 0;
      for (int i = 0; i < 500; i++) begin
        if (len_ss == 0) begin
          lvl_ss = ~lvl_ss;
          len_ss = $urandom_range(1, 12);
        end
        if (len_cl == 0) begin
          lvl_cl = ~lvl_cl;
          len_cl = $urandom_range(1, 12);
        end
        rr = ($urandom_range(0, 299) == 0);
        cyc(rr, lvl_ss, lvl_cl);
        len_ss--;
        len_cl--;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sw_ctrl.md
Name: sw_ctrl

Overview:
- Control front end of the stop-watch, directly upstream of the cascaded divider/counter chain.
- Debounces the start/stop and clear/lap push-buttons and runs the run/pause/lap state machine.
- Prescales the system clock into a one-cycle count-enable pulse, which drives the first stage's carry-in.
- Also issues the chain clear pulse and a display-hold flag.

Parameters:
- DIV, 500000: clk cycles per output tick (50 MHz -> 100 Hz); DIV >= 2.
- DB_CYCLES, 1000000: consecutive stable samples required to accept a button level (20 ms at 50 MHz); DB_CYCLES >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_ss  in  1  raw start/stop button, 1 = pressed, asynchronous to clk.
- btn_cl  in  1  raw clear/lap button, 1 = pressed, asynchronous to clk.
- tick  out  1  count enable to chain carry-in; one-cycle pulse.
- clr  out  1  one-cycle clear pulse to the counter chain.
- hold  out  1  1 = display latch frozen (lap view).
- state  out  2  current FSM state, for LEDs and debug.

Behaviour:
- Reset: every register is cleared on the first rising edge with rst=1. Resulting values:
  - state=IDLE, tick=0, clr=0, hold=0.
  - Prescaler pre=0.
  - Synchronisers, debounce stable levels and debounce counters = 0.
- Debounce, per button:
  - Raw input passes through a 2-flop synchroniser to give s.
  - Counter cnt resets to 0 whenever s == stable. Otherwise it increments.
  - When cnt reaches DB_CYCLES-1 with s != stable: stable <= s and cnt <= 0.
  - Press event = stable & ~stable_d, high for exactly one cycle.
  - Latency: raw first sampled high at edge N gives a press event during the cycle after edge N+DB_CYCLES+1. The state change occurs at edge N+DB_CYCLES+2.
  - Glitches shorter than DB_CYCLES cycles produce no event.
  - Release produces no event.
  - A button held through reset produces one press event DB_CYCLES+2 cycles after rst deasserts.
- FSM, encoding IDLE=0, RUN=1, PAUSE=2, LAP=3. Transitions:
  - IDLE: ss -> RUN. cl -> stay IDLE, pulse clr.
  - RUN: ss -> PAUSE. cl -> LAP.
  - LAP: ss -> PAUSE, hold drops. cl -> RUN, hold drops.
  - PAUSE: ss -> RUN. cl -> IDLE, pulse clr.
- Simultaneous ss and cl events in one cycle: ss wins and cl is discarded.
- clr is registered and goes high in the cycle following the transitioning edge, for exactly one cycle.
- hold is registered and equals 1 exactly while state == LAP.
- Prescaler pre, width $clog2(DIV):
  - Counting (state RUN or LAP): pre increments and wraps from DIV-1 to 0.
  - tick = counting & (pre == DIV-1), combinational from registers.
  - PAUSE: pre holds its value, so the fractional phase is kept across pause/resume.
  - IDLE: pre forced to 0.
- tick and clr are never high in the same cycle.
- rst asserted mid-count: next edge returns everything to reset values. No tick or clr is emitted in that cycle.

Optional Feature:
- Macro: SW_LAP_EN.
- Defined: LAP state and the hold behaviour as above.
- Undefined:
  - cl events in RUN are ignored.
  - LAP state is unreachable and not synthesised.
  - hold is tied to 0.
  - state never reads 3.

Decomposition:
- Package sw_pkg holds:
  - State encoding constants IDLE/RUN/PAUSE/LAP as a 2-bit typedef sw_state_t.
  - Default DIV and DB_CYCLES constants.
- Sub-module sw_debounce (parameter DB_CYCLES; ports clk, rst, raw, press) is instantiated twice.
- Prescaler and FSM stay in sw_ctrl.

Test Plan:
All scenarios use DIV=5, DB_CYCLES=4.
1. Reset, then btn_ss high for 10 cycles -> state=RUN at edge N+6. After that, tick pulses every 5 cycles, first tick 5 cycles after entering RUN.
2. btn_ss glitch high for 3 cycles while IDLE -> no state change, tick stays 0, clr stays 0.
3. RUN for 7 cycles (pre=2), press ss -> PAUSE with pre held at 2 and no ticks. Press ss again -> RUN, first tick exactly 2 cycles (pre 3->4) after resuming.
4. From PAUSE, press cl -> state=IDLE with one clr pulse the following cycle, and pre=0. Press cl again in IDLE -> second clr pulse, state stays IDLE.
5. With SW_LAP_EN: RUN, press cl -> state=LAP, hold=1, ticks continue. Press cl -> RUN, hold=0. Without SW_LAP_EN: same stimulus -> state stays RUN, hold=0.
6. Both buttons rise in the same cycle in RUN -> state=PAUSE, no LAP, no clr. Assert rst mid-RUN -> next cycle state=IDLE and all outputs 0.
